// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serdes_pkg
// Brief    : Shared PAM4 sample type, TX phase enum, Gray map and clamp.
// Revision : 1.0 - initial release
// ============================================================================
package serdes_pkg;

    typedef logic signed [7:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        DATA  = 2'd2
    } tx_state_t;

    // Gray-coded dibit per PAM4 level, first bit in the MSB
    localparam logic [1:0] c_gray_n3 = 2'b00;
    localparam logic [1:0] c_gray_n1 = 2'b01;
    localparam logic [1:0] c_gray_p1 = 2'b11;
    localparam logic [1:0] c_gray_p3 = 2'b10;

    function automatic sample_t pam4_gray_map(input logic [1:0] bits, input sample_t level);
        sample_t l3;
        sample_t v;
        l3 = level + level + level;
        case (bits)
            c_gray_n3: v = -l3;
            c_gray_n1: v = -level;
            c_gray_p1: v = level;
            c_gray_p3: v = l3;
            default:   v = '0;
        endcase
        return v;
    endfunction

    function automatic sample_t sat8(input logic signed [17:0] x);
        sample_t v;
        if (x > 18'sd127) begin
            v = 8'sh7F;
        end else if (x < -18'sd128) begin
            v = 8'sh80;
        end else begin
            v = x[7:0];
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs7_gen.sv
`default_nettype none
// ============================================================================
// Module   : prbs7_gen
// Brief    : PRBS7 (x^7+x^6+1, Fibonacci) emitting two bits per step.
// Revision : 1.0 - initial release
// ============================================================================
module prbs7_gen #(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_step,
    output logic [1:0] o_bits
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [6:0] c_seed = (SEED == 7'h00) ? 7'h01 : SEED;

    logic [6:0] r_lfsr;
    logic       w_b0;
    logic       w_b1;

    assign w_b0   = r_lfsr[6] ^ r_lfsr[5];
    assign w_b1   = r_lfsr[5] ^ r_lfsr[4];
    assign o_bits = {w_b0, w_b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= c_seed;
        end else if (i_load) begin
            r_lfsr <= c_seed;
        end else if (i_step) begin
            r_lfsr <= {r_lfsr[4:0], w_b0, w_b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_pam4_ffe.sv
`default_nettype none
// ============================================================================
// Module   : tx_pam4_ffe
// Brief    : PRBS7 PAM4 transmitter with 3-tap FFE, additive noise and
//            training-phase sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module tx_pam4_ffe #(
    parameter logic [6:0] PRBS_SEED = 7'h7F,
    parameter int         LEVEL     = 32,
    parameter int         TAP_SHIFT = 6,
    parameter int         RATE_DIV  = 1,
    parameter int         TRAIN_LEN = 64
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       tx_en,
    input  logic [7:0] tap_main,
    input  logic [7:0] tap_post1,
    input  logic [7:0] tap_post2,
    input  logic [7:0] noise,
    output logic [7:0] signal_out,
    output logic       signal_out_valid,
    output logic [7:0] train_data,
    output logic       train_data_valid,
    output logic       busy
);

    import serdes_pkg::*;

    localparam int                  c_rate_w     = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam int                  c_sym_w      = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN + 1) : 1;
    localparam logic [c_rate_w-1:0] c_rate_last  = c_rate_w'(RATE_DIV - 1);
    localparam logic [c_sym_w-1:0]  c_train_last = c_sym_w'(TRAIN_LEN - 1);
    localparam sample_t             c_level      = sample_t'(LEVEL);

    tx_state_t           r_state;
    tx_state_t           w_state_nxt;
    logic [c_rate_w-1:0] r_rate_cnt;
    logic [c_sym_w-1:0]  r_sym_cnt;
    logic                w_run;
    logic                w_start;
    logic                w_tick;
    logic [1:0]          w_bits;

    sample_t             r_s0, r_s1, r_s2;
    logic                r_v1, r_tag1;
    logic                r_v2, r_tag2;
    sample_t             r_sym2;
    logic signed [17:0]  r_sum;
    logic signed [15:0]  w_p0, w_p1, w_p2;
    logic signed [17:0]  w_sum;
    logic signed [17:0]  w_shifted;
    logic signed [17:0]  w_noisy;

    sample_t             r_signal_out;
    sample_t             r_train_data;
    logic                r_signal_out_valid;
    logic                r_train_data_valid;

    assign w_run   = (r_state == TRAIN) || (r_state == DATA);
    assign w_start = (r_state == IDLE) && tx_en;
    // Dropping tx_en suppresses the tick in the same cycle so no new symbol enters
    assign w_tick  = w_run && tx_en && (r_rate_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (tx_en) w_state_nxt = TRAIN;
            end
            TRAIN: begin
                if (!tx_en) begin
                    w_state_nxt = IDLE;
                end else if (w_tick && (r_sym_cnt == c_train_last)) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (!tx_en) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= IDLE;
            r_rate_cnt <= '0;
            r_sym_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_rate_cnt <= '0;
                r_sym_cnt  <= '0;
            end else begin
                if (w_run && tx_en) begin
                    r_rate_cnt <= (r_rate_cnt == c_rate_last) ? '0 : r_rate_cnt + 1'b1;
                end
                if (w_tick && (r_state == TRAIN) && (r_sym_cnt != c_train_last)) begin
                    r_sym_cnt <= r_sym_cnt + 1'b1;
                end
            end
        end
    end

    prbs7_gen #(
        .SEED (PRBS_SEED)
    ) u_prbs (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .i_load (w_start),
        .i_step (w_tick),
        .o_bits (w_bits)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_s0 <= '0;
            r_s1 <= '0;
            r_s2 <= '0;
        end else if (w_start) begin
            r_s0 <= '0;
            r_s1 <= '0;
            r_s2 <= '0;
        end else if (w_tick) begin
            r_s2 <= r_s1;
            r_s1 <= r_s0;
            r_s0 <= pam4_gray_map(w_bits, c_level);
        end
    end

    assign w_p0      = $signed(tap_main)  * r_s0;
    assign w_p1      = $signed(tap_post1) * r_s1;
    assign w_p2      = $signed(tap_post2) * r_s2;
    assign w_sum     = 18'(w_p0) + 18'(w_p1) + 18'(w_p2);
    assign w_shifted = r_sum >>> TAP_SHIFT;
    assign w_noisy   = w_shifted + 18'($signed(noise));

    // Pipeline tags are not cleared on restart so drained symbols keep their phase
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_v1               <= 1'b0;
            r_tag1             <= 1'b0;
            r_v2               <= 1'b0;
            r_tag2             <= 1'b0;
            r_sym2             <= '0;
            r_sum              <= '0;
            r_signal_out       <= '0;
            r_train_data       <= '0;
            r_signal_out_valid <= 1'b0;
            r_train_data_valid <= 1'b0;
        end else begin
            r_v1 <= w_tick;
            if (w_tick) r_tag1 <= (r_state == TRAIN);
            r_v2 <= r_v1;
            if (r_v1) begin
                r_tag2 <= r_tag1;
                r_sym2 <= r_s0;
                r_sum  <= w_sum;
            end
            r_signal_out_valid <= r_v2;
            r_train_data_valid <= r_v2 & r_tag2;
            if (r_v2) begin
                r_signal_out <= sat8(w_noisy);
                r_train_data <= r_sym2;
            end
        end
    end

    assign signal_out       = r_signal_out;
    assign train_data       = r_train_data;
    assign signal_out_valid = r_signal_out_valid;
    assign train_data_valid = r_train_data_valid;
    assign busy             = (r_state != IDLE) | r_v1 | r_v2;

endmodule
`default_nettype wire

// File: tb/tb_tx_pam4_ffe.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_pam4_ffe
// Brief    : Directed self-checking bench for tx_pam4_ffe (three instances:
//            seed 7F/RATE_DIV 1, seed 4C/RATE_DIV 1, seed 7F/RATE_DIV 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_pam4_ffe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tap_main, tap_post1, tap_post2, noise;
    logic       tx_en [3];
    logic [7:0] so    [3];
    logic       sov   [3];
    logic [7:0] td    [3];
    logic       tdv   [3];
    logic       bsy   [3];

    int         n_vec = 0;
    int         n_err = 0;

    logic [7:0] cap_so  [64];
    logic [7:0] cap_td  [64];
    logic       cap_tdv [64];
    int         cap_cyc [64];
    int         n_cap;

    // Hand-derived symbols for seed 7F: -96,-96,-96,+96,-96,-96,+32,-96
    logic [7:0] exp_sym [8];

    always #5 clk = ~clk;

    tx_pam4_ffe #(.PRBS_SEED(7'h7F), .LEVEL(32), .TAP_SHIFT(6), .RATE_DIV(1), .TRAIN_LEN(4)) u_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .tx_en(tx_en[0]),
        .tap_main(tap_main), .tap_post1(tap_post1), .tap_post2(tap_post2), .noise(noise),
        .signal_out(so[0]), .signal_out_valid(sov[0]), .train_data(td[0]),
        .train_data_valid(tdv[0]), .busy(bsy[0]));

    tx_pam4_ffe #(.PRBS_SEED(7'h4C), .LEVEL(32), .TAP_SHIFT(6), .RATE_DIV(1), .TRAIN_LEN(4)) u_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .tx_en(tx_en[1]),
        .tap_main(tap_main), .tap_post1(tap_post1), .tap_post2(tap_post2), .noise(noise),
        .signal_out(so[1]), .signal_out_valid(sov[1]), .train_data(td[1]),
        .train_data_valid(tdv[1]), .busy(bsy[1]));

    tx_pam4_ffe #(.PRBS_SEED(7'h7F), .LEVEL(32), .TAP_SHIFT(6), .RATE_DIV(4), .TRAIN_LEN(4)) u_c (
        .clk_clk(clk), .reset_reset_n(rst_n), .tx_en(tx_en[2]),
        .tap_main(tap_main), .tap_post1(tap_post1), .tap_post2(tap_post2), .noise(noise),
        .signal_out(so[2]), .signal_out_valid(sov[2]), .train_data(td[2]),
        .train_data_valid(tdv[2]), .busy(bsy[2]));

    task automatic run_capture(input int inst, input int ncyc, input int drop_at, input int raise_at);
        n_cap = 0;
        @(negedge clk);
        tx_en[inst] = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (sov[inst]) begin
                if (n_cap < 64) begin
                    cap_so[n_cap]  = so[inst];
                    cap_td[n_cap]  = td[inst];
                    cap_tdv[n_cap] = tdv[inst];
                    cap_cyc[n_cap] = c;
                end
                n_cap++;
            end
            if (c == drop_at)  tx_en[inst] = 1'b0;
            if (c == raise_at) tx_en[inst] = 1'b1;
        end
    endtask

    task automatic stop_inst(input int inst);
        @(negedge clk);
        tx_en[inst] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) tx_en[k] = 1'b0;
        tap_main = 8'd0; tap_post1 = 8'd0; tap_post2 = 8'd0; noise = 8'd0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({so[k], sov[k], td[k], tdv[k], bsy[k]} !== 19'd0) begin
                n_err++;
                $display("FAIL reset_outputs[%0d]: got so=%h sov=%b td=%h tdv=%b busy=%b expected all 0",
                         k, so[k], sov[k], td[k], tdv[k], bsy[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_quiet;
        int strobes;
        strobes = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (sov[k] || tdv[k] || bsy[k]) strobes++;
        end
        n_vec++;
        if (strobes !== 0) begin
            n_err++;
            $display("FAIL idle_quiet: got %0d active samples expected 0", strobes);
        end
    endtask

    task automatic test_unity;
        tap_main = 8'd64; tap_post1 = 8'd0; tap_post2 = 8'd0; noise = 8'd0;
        run_capture(0, 16, -1, -1);
        n_vec++;
        if (n_cap !== 13) begin
            n_err++;
            $display("FAIL unity_count: got %0d expected 13", n_cap);
        end
        n_vec++;
        if (cap_cyc[0] !== 3) begin
            n_err++;
            $display("FAIL unity_latency: got %0d expected 3", cap_cyc[0]);
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (cap_so[i] !== exp_sym[i] || cap_td[i] !== exp_sym[i]) begin
                n_err++;
                $display("FAIL unity_sym[%0d]: got so=%0d td=%0d expected %0d",
                         i, $signed(cap_so[i]), $signed(cap_td[i]), $signed(exp_sym[i]));
            end
            n_vec++;
            if (cap_tdv[i] !== (i < 4)) begin
                n_err++;
                $display("FAIL unity_tdv[%0d]: got %b expected %b", i, cap_tdv[i], (i < 4));
            end
        end
        stop_inst(0);
    endtask

    task automatic test_isi;
        tap_main = 8'd64; tap_post1 = 8'd16; tap_post2 = 8'd0; noise = 8'd0;
        run_capture(1, 8, -1, -1);
        n_vec++;
        if (cap_so[0] !== 8'(96) || cap_so[1] !== 8'(120)) begin
            n_err++;
            $display("FAIL isi_same_sign: got %0d,%0d expected 96,120",
                     $signed(cap_so[0]), $signed(cap_so[1]));
        end
        stop_inst(1);
        run_capture(0, 8, -1, -1);
        n_vec++;
        if (cap_so[2] !== 8'(-120)) begin
            n_err++;
            $display("FAIL isi_neg_pair: got %0d expected -120", $signed(cap_so[2]));
        end
        n_vec++;
        if (cap_so[3] !== 8'(72)) begin
            n_err++;
            $display("FAIL isi_opposite: got %0d expected 72", $signed(cap_so[3]));
        end
        stop_inst(0);
    endtask

    task automatic test_sat_high;
        tap_main = 8'd127; tap_post1 = 8'd127; tap_post2 = 8'd127; noise = 8'd0;
        run_capture(1, 8, -1, -1);
        n_vec++;
        if (cap_so[2] !== 8'(127) || cap_td[2] !== 8'(96)) begin
            n_err++;
            $display("FAIL sat_high: got so=%0d td=%0d expected 127,96",
                     $signed(cap_so[2]), $signed(cap_td[2]));
        end
        n_vec++;
        if (cap_so[0] !== 8'(127)) begin
            n_err++;
            $display("FAIL sat_high_single: got %0d expected 127", $signed(cap_so[0]));
        end
        stop_inst(1);
    endtask

    task automatic test_sat_low;
        tap_main = 8'd64; tap_post1 = 8'd0; tap_post2 = 8'd0; noise = 8'h80;
        run_capture(0, 8, -1, -1);
        n_vec++;
        if (cap_so[0] !== 8'(-128) || cap_td[0] !== 8'(-96)) begin
            n_err++;
            $display("FAIL sat_low: got so=%0d td=%0d expected -128,-96",
                     $signed(cap_so[0]), $signed(cap_td[0]));
        end
        n_vec++;
        if (cap_so[3] !== 8'(-32)) begin
            n_err++;
            $display("FAIL sat_low_noise_add: got %0d expected -32", $signed(cap_so[3]));
        end
        stop_inst(0);
        noise = 8'd0;
    endtask

    task automatic test_rate_div;
        tap_main = 8'd64; tap_post1 = 8'd0; tap_post2 = 8'd0; noise = 8'd0;
        run_capture(2, 30, -1, -1);
        n_vec++;
        if (n_cap !== 7) begin
            n_err++;
            $display("FAIL rate_count: got %0d expected 7", n_cap);
        end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (cap_cyc[i] !== 3 + 4 * i || cap_so[i] !== exp_sym[i] || cap_tdv[i] !== (i < 4)) begin
                n_err++;
                $display("FAIL rate_strobe[%0d]: got cyc=%0d so=%0d tdv=%b expected cyc=%0d so=%0d tdv=%b",
                         i, cap_cyc[i], $signed(cap_so[i]), cap_tdv[i],
                         3 + 4 * i, $signed(exp_sym[i]), (i < 4));
            end
        end
        stop_inst(2);
    endtask

    task automatic test_abort_restart;
        tap_main = 8'd64; tap_post1 = 8'd0; tap_post2 = 8'd0; noise = 8'd0;
        run_capture(0, 12, 2, -1);
        n_vec++;
        if (n_cap !== 2 || cap_cyc[0] !== 3 || cap_cyc[1] !== 4) begin
            n_err++;
            $display("FAIL abort_drain: got %0d strobes (first cyc %0d,%0d) expected 2 at 3,4",
                     n_cap, cap_cyc[0], cap_cyc[1]);
        end
        n_vec++;
        if (bsy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_busy: got %b expected 0", bsy[0]);
        end
        stop_inst(0);
        run_capture(0, 16, 2, 3);
        n_vec++;
        if (n_cap !== 11 || cap_cyc[2] !== 7) begin
            n_err++;
            $display("FAIL restart_timing: got %0d strobes, restart at cyc %0d expected 11, 7",
                     n_cap, cap_cyc[2]);
        end
        n_vec++;
        if (cap_tdv[0] !== 1'b1 || cap_tdv[1] !== 1'b1) begin
            n_err++;
            $display("FAIL restart_drain_tag: got %b%b expected 11", cap_tdv[0], cap_tdv[1]);
        end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (cap_so[i + 2] !== exp_sym[i] || cap_tdv[i + 2] !== (i < 4)) begin
                n_err++;
                $display("FAIL restart_sym[%0d]: got so=%0d tdv=%b expected so=%0d tdv=%b",
                         i, $signed(cap_so[i + 2]), cap_tdv[i + 2], $signed(exp_sym[i]), (i < 4));
            end
        end
        stop_inst(0);
    endtask

    initial begin
        exp_sym[0] = 8'(-96); exp_sym[1] = 8'(-96); exp_sym[2] = 8'(-96); exp_sym[3] = 8'(96);
        exp_sym[4] = 8'(-96); exp_sym[5] = 8'(-96); exp_sym[6] = 8'(32);  exp_sym[7] = 8'(-96);
        test_reset();
        test_idle_quiet();
        test_unity();
        test_isi();
        test_sat_high();
        test_sat_low();
        test_rate_div();
        test_abort_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
